ct_spsram_256x7_ctrl: RTL and testbench

Initiator-side controller for the 256x7 single-port SRAM macro port (A/CEN/GWEN/WEN/D/Q). After reset it clears the array to a known value by sweeping every address. It then accepts read and write requests on a valid/ready interface and drives the macro pins. Read data returns on a separate valid/ready response channel, buffered so the requester may apply backpressure. It sits between a cache/predictor pipeline and one ct_spsram_256x7 instance.

---
 rtl/ct_spsram_256x7_ctrl.sv | 121 ++++++++++++
 tb/tb_ct_spsram_256x7_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_256x7_ctrl.sv
`default_nettype none
// ============================================================================
// ct_spsram_256x7_ctrl : sweep-clear + valid/ready front end for a 256x7 SP SRAM
// Rev 1.0
// ============================================================================
module ct_spsram_256x7_ctrl #(
   parameter bit         INIT_EN  = 1'b1,
   parameter logic [6:0] INIT_VAL = 7'h00
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       req_vld,
   output logic       req_rdy,
   input  logic       req_wr,
   input  logic [7:0] req_addr,
   input  logic [6:0] req_wdata,
   input  logic [6:0] req_wmask,
   output logic       rsp_vld,
   input  logic       rsp_rdy,
   output logic [6:0] rsp_rdata,
   output logic       init_done,
   output logic [7:0] A,
   output logic       CEN,
   output logic       GWEN,
   output logic [6:0] WEN,
   output logic [6:0] D,
   input  logic [6:0] Q
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_icnt;
   logic       r_inflight;
   logic [1:0] r_cnt;
   logic       r_wptr;
   logic       r_rptr;
   logic [6:0] r_mem [0:1];

   logic       w_run;
   logic       w_sweep;
   logic       w_pop;
   logic       w_accept;
   logic [2:0] w_occ;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= INIT_EN ? ST_INIT : ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_INIT && r_icnt == 8'hFF) begin
         w_state_nxt = ST_RUN;
      end
   end

   // Outputs are gated by RST so the macro stays idle while reset is held.
   always_comb begin
      w_run     = (r_state == ST_RUN) && !RST;
      w_sweep   = (r_state == ST_INIT) && !RST;
      w_pop     = (r_cnt != 2'd0) && rsp_rdy;
      w_occ     = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
      init_done = w_run;
      req_rdy   = w_run && (w_occ < 3'd2);
      w_accept  = req_vld && req_rdy;
      rsp_vld   = (r_cnt != 2'd0);
      rsp_rdata = r_mem[r_rptr];

      A    = req_addr;
      D    = req_wdata;
      WEN  = ~req_wmask;
      GWEN = ~req_wr;
      CEN  = ~w_accept;
      if (w_sweep) begin
         A    = r_icnt;
         D    = INIT_VAL;
         WEN  = 7'h00;
         GWEN = 1'b0;
         CEN  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_icnt     <= 8'h00;
         r_inflight <= 1'b0;
         r_cnt      <= 2'd0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
      end else begin
         if (r_state == ST_INIT) begin
            r_icnt <= r_icnt + 8'h01;
         end
         // Q is only valid the cycle after the read edge, so capture then.
         r_inflight <= w_accept && !req_wr;
         if (r_inflight) begin
            r_wptr <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && r_inflight) begin
         r_mem[r_wptr] <= Q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ct_spsram_256x7_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ct_spsram_256x7_ctrl : directed self-checking bench with macro models
// Rev 1.0
// ============================================================================
module tb_ct_spsram_256x7_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_vld = 1'b0, req_wr = 1'b0, rsp_rdy = 1'b1;
   logic [7:0] req_addr = 8'h00;
   logic [6:0] req_wdata = 7'h00, req_wmask = 7'h00;
   logic       req_rdy, rsp_vld, init_done, cen, gwen;
   logic [6:0] rsp_rdata, wen, d, q;
   logic [7:0] a;

   logic       rst2 = 1'b1;
   logic       req_vld2 = 1'b0, req_wr2 = 1'b0, rsp_rdy2 = 1'b1;
   logic [7:0] req_addr2 = 8'h00;
   logic [6:0] req_wdata2 = 7'h00, req_wmask2 = 7'h00;
   logic       req_rdy2, rsp_vld2, init_done2, cen2, gwen2;
   logic [6:0] rsp_rdata2, wen2, d2, q2;
   logic [7:0] a2;

   logic [6:0] mem1 [0:255];
   logic [6:0] mem2 [0:255];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ct_spsram_256x7_ctrl #(.INIT_EN(1'b1), .INIT_VAL(7'h55)) u_dut (
      .CLK(clk), .RST(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .init_done(init_done),
      .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d), .Q(q)
   );

   ct_spsram_256x7_ctrl #(.INIT_EN(1'b0), .INIT_VAL(7'h00)) u_dut2 (
      .CLK(clk), .RST(rst2), .req_vld(req_vld2), .req_rdy(req_rdy2), .req_wr(req_wr2),
      .req_addr(req_addr2), .req_wdata(req_wdata2), .req_wmask(req_wmask2),
      .rsp_vld(rsp_vld2), .rsp_rdy(rsp_rdy2), .rsp_rdata(rsp_rdata2), .init_done(init_done2),
      .A(a2), .CEN(cen2), .GWEN(gwen2), .WEN(wen2), .D(d2), .Q(q2)
   );

   // Behavioural macros: sample on the rising edge, read data valid next cycle.
   always @(posedge clk) begin
      if (cen === 1'b0) begin
         if (gwen) q <= mem1[a];
         else      mem1[a] <= (mem1[a] & wen) | (d & ~wen);
      end
      if (cen2 === 1'b0) begin
         if (gwen2) q2 <= mem2[a2];
         else       mem2[a2] <= (mem2[a2] & wen2) | (d2 & ~wen2);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] ad, input logic [6:0] dat, input logic [6:0] msk);
      req_vld = 1'b1; req_wr = 1'b1; req_addr = ad; req_wdata = dat; req_wmask = msk;
      @(negedge clk);
      check("wr_rdy", req_rdy, 1'b1);
      next_cyc();
      req_vld = 1'b0; req_wr = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [7:0] ad, input logic [6:0] exp);
      rsp_rdy = 1'b1;
      req_vld = 1'b1; req_wr = 1'b0; req_addr = ad;
      @(negedge clk);
      check({tag, "_rdy"}, req_rdy, 1'b1);
      next_cyc();
      req_vld = 1'b0;
      @(negedge clk);
      check({tag, "_early"}, rsp_vld, 1'b0);
      next_cyc();
      @(negedge clk);
      check({tag, "_vld"}, rsp_vld, 1'b1);
      check({tag, "_data"}, rsp_rdata, exp);
      next_cyc();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, n;
      logic [7:0] ad;
      logic [6:0] ev;

      // Reset state
      repeat (3) next_cyc();
      @(negedge clk);
      check("rst_rsp_vld", rsp_vld, 1'b0);
      check("rst_req_rdy", req_rdy, 1'b0);
      check("rst_init_done", init_done, 1'b0);
      check("rst_cen", cen, 1'b1);
      next_cyc();
      rst = 1'b0;

      // Sweep: 256 write cycles with A = 0..255
      bad = 0;
      for (int c = 0; c < 256; c++) begin
         @(negedge clk);
         if (cen !== 1'b0 || gwen !== 1'b0 || wen !== 7'h00 || d !== 7'h55 ||
             a !== c[7:0] || init_done !== 1'b0 || req_rdy !== 1'b0) bad++;
      end
      check("sweep_bad_cycles", bad, 0);
      @(negedge clk);
      check("sweep_done_256", init_done, 1'b1);
      check("sweep_done_cen", cen, 1'b1);
      next_cyc();
      rd_check("rd_a3", 8'hA3, 7'h55);

      // Masked writes
      wr(8'h10, 7'h7F, 7'h7F);
      wr(8'h10, 7'h00, 7'h0F);
      rd_check("rd_mask", 8'h10, 7'h70);

      // Backpressure
      wr(8'h01, 7'h11, 7'h7F);
      wr(8'h02, 7'h22, 7'h7F);
      wr(8'h03, 7'h33, 7'h7F);
      rsp_rdy = 1'b0;
      req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h01;
      @(negedge clk); check("bp_rdy1", req_rdy, 1'b1); next_cyc();
      req_addr = 8'h02;
      @(negedge clk); check("bp_rdy2", req_rdy, 1'b1); next_cyc();
      req_addr = 8'h03;
      @(negedge clk); check("bp_rdy3_blocked", req_rdy, 1'b0); next_cyc();
      @(negedge clk); check("bp_rdy3_full", req_rdy, 1'b0);
      check("bp_full_cen", cen, 1'b1); next_cyc();
      rsp_rdy = 1'b1;
      @(negedge clk);
      check("bp_rsp1", rsp_rdata, 7'h11);
      check("bp_rsp1_vld", rsp_vld, 1'b1);
      check("bp_rdy3_on_pop", req_rdy, 1'b1);
      next_cyc();
      req_vld = 1'b0;
      @(negedge clk);
      check("bp_rsp2", rsp_rdata, 7'h22);
      check("bp_rsp2_vld", rsp_vld, 1'b1);
      next_cyc();
      @(negedge clk);
      check("bp_rsp3", rsp_rdata, 7'h33);
      check("bp_rsp3_vld", rsp_vld, 1'b1);
      next_cyc();
      @(negedge clk);
      check("bp_empty", rsp_vld, 1'b0);

      // Streaming writes then 64 reads at full rate
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         ad = 8'h40 + i[7:0];
         req_vld = 1'b1; req_wr = 1'b1; req_addr = ad;
         req_wdata = ad[6:0] ^ 7'h2A; req_wmask = 7'h7F;
         @(negedge clk);
         if (req_rdy !== 1'b1) bad++;
         next_cyc();
      end
      check("stream_wr_stalls", bad, 0);
      req_wr = 1'b0;
      bad = 0;
      n = 0;
      for (int i = 0; i < 66; i++) begin
         req_vld = (i < 64);
         ad = 8'h40 + i[7:0];
         req_addr = ad;
         @(negedge clk);
         if (i < 64 && req_rdy !== 1'b1) n++;
         if (i < 2) begin
            if (rsp_vld !== 1'b0) bad++;
         end else begin
            ad = 8'h40 + i[7:0] - 8'd2;
            ev = ad[6:0] ^ 7'h2A;
            if (rsp_vld !== 1'b1 || rsp_rdata !== ev) bad++;
         end
         next_cyc();
      end
      req_vld = 1'b0;
      check("stream_rd_stalls", n, 0);
      check("stream_rd_bad_rsp", bad, 0);

      // Reset with one FIFO entry and one read in flight
      rsp_rdy = 1'b0;
      req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h10;
      @(negedge clk); check("mrst_rd1", req_rdy, 1'b1); next_cyc();
      req_addr = 8'h01;
      @(negedge clk); check("mrst_rd2", req_rdy, 1'b1); next_cyc();
      req_vld = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("mrst_pre_vld", rsp_vld, 1'b1);
      check("mrst_pre_cen", cen, 1'b1);
      next_cyc();
      @(negedge clk);
      check("mrst_vld", rsp_vld, 1'b0);
      check("mrst_cen", cen, 1'b1);
      check("mrst_rdy", req_rdy, 1'b0);
      next_cyc();
      rst = 1'b0;
      @(negedge clk);
      check("mrst_sweep_cen", cen, 1'b0);
      check("mrst_sweep_a0", a, 8'h00);
      check("mrst_sweep_gwen", gwen, 1'b0);
      n = 0;
      while (init_done !== 1'b1 && n < 400) begin
         next_cyc();
         n++;
      end
      check("mrst_sweep_len", n, 256);
      check("mrst_no_stale_rsp", rsp_vld, 1'b0);
      rd_check("mrst_cleared", 8'h10, 7'h55);

      // INIT_EN=0 instance
      rst2 = 1'b1;
      repeat (2) next_cyc();
      rst2 = 1'b0;
      req_vld2 = 1'b1; req_wr2 = 1'b1; req_addr2 = 8'h05; req_wdata2 = 7'h3C; req_wmask2 = 7'h7F;
      @(negedge clk);
      check("noinit_done", init_done2, 1'b1);
      check("noinit_rdy", req_rdy2, 1'b1);
      check("noinit_cen", cen2, 1'b0);
      check("noinit_gwen", gwen2, 1'b0);
      next_cyc();
      req_wr2 = 1'b0;
      @(negedge clk); check("noinit_rd_rdy", req_rdy2, 1'b1); next_cyc();
      req_vld2 = 1'b0;
      @(negedge clk); check("noinit_rd_early", rsp_vld2, 1'b0); next_cyc();
      @(negedge clk);
      check("noinit_rd_vld", rsp_vld2, 1'b1);
      check("noinit_rd_data", rsp_rdata2, 7'h3C);
      next_cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
